alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
//   Operand-fetch / issue stage directly upstream of the ALU. Holds the
//   architectural register file, reads source operands for each decoded op,
//   tracks in-flight destinations with a busy scoreboard, and stalls on hazards.
//   Issues a registered {a, b, aluc, rd} packet to the execute stage over valid/ready.
//   Accepts ALU results back through a writeback port.
// PARAMETERS
//   XLEN  32  datapath / register width
//   NREG  32  number of architectural registers (r0 hardwired to zero)
//   RIDX  5   register index width, = clog2(NREG)
// PORTS
//   clk         in   1     clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   in_valid    in   1     decoded op present
//   in_ready    out  1     op accepted this cycle when in_valid && in_ready
//   in_rs1      in   RIDX  source 1 index
//   in_rs2      in   RIDX  source 2 index (ignored when in_use_imm)
//   in_rd       in   RIDX  destination index
//   in_wen      in   1     op writes in_rd
//   in_use_imm  in   1     b operand = in_imm instead of reg[in_rs2]
//   in_imm      in   XLEN  immediate
//   in_aluc     in   4     ALU opcode, passed through unmodified
//   out_valid   out  1     issue packet valid
//   out_ready   in   1     execute stage consumes packet
//   out_a       out  XLEN  operand a
//   out_b       out  XLEN  operand b
//   out_aluc    out  4     ALU opcode
//   out_rd      out  RIDX  destination index
//   out_wen     out  1     destination write enable
//   wb_valid    in   1     writeback strobe
//   wb_rd       in   RIDX  writeback index
//   wb_data     in   XLEN  writeback data
// BEHAVIOUR
//   Reset (async, rst_n=0): all registers = 0, busy[] = 0, out_valid = 0,
//     out_a/out_b/out_aluc/out_rd/out_wen = 0. Takes effect without a clock edge.
//   Register file: NREG x XLEN. Writes are synchronous on wb_valid.
//     Writes to r0 are discarded; r0 always reads 0.
//   Bypass: a read of register x in the same cycle as wb_valid && wb_rd==x (x!=0)
//     returns wb_data.
//   Scoreboard: busy[x] set at the accept edge when in_wen && in_rd!=0.
//     busy[wb_rd] cleared at the writeback edge. If set and clear hit the same
//     index in one cycle, set wins. busy[0] is always 0. A writeback to a
//     non-busy register still writes data; the busy clear is a no-op.
//   Hazard (combinational):
//     (busy[rs1] && !(wb_valid && wb_rd==rs1))
//     || (!in_use_imm && busy[rs2] && !(wb_valid && wb_rd==rs2))
//     || (in_wen && busy[rd] && !(wb_valid && wb_rd==rd))   [WAW].
//   Issue slot, two states:
//     EMPTY: out_valid=0. Moves to FULL on accept.
//     FULL:  out_valid=1. Moves to EMPTY on out_ready with no new accept;
//            reloads on out_ready with accept.
//   in_ready = !hazard && (!out_valid || out_ready). It may depend on in_*, so
//     in_valid must not depend on in_ready.
//   Accept: out_* registered at the accept edge. Latency is one cycle, in -> out_valid.
//   Stall: while out_valid && !out_ready, all out_* hold stable and in_ready=0.
//   out_b = in_use_imm ? in_imm : reg[in_rs2] (bypassed). out_a = reg[in_rs1] (bypassed).
// TESTING
//   1. Release reset, out_ready=1; issue rs1=0, rs2=0, aluc=4'b1000
//      -> next cycle out_valid=1, out_a=0, out_b=0, out_aluc=4'b1000.
//   2. wb x5=0x0000_1234; then issue rs1=5, use_imm=1, imm=7
//      -> out_a=0x1234, out_b=7.
//   3. Issue rd=3, wen=1; then op with rs1=3 -> in_ready=0 for 3 cycles.
//      Then wb_rd=3, wb_data=0xAA -> accepted the same cycle, out_a=0xAA.
//   4. out_ready=0 for 5 cycles with out_valid=1 -> out_* stable, in_ready=0.
//      Raise out_ready -> pending op issued next edge.
//   5. wb_rd=0, wb_data=0xFFFF_FFFF -> rs1=0 reads 0.
//      Issue rd=0, wen=1, then rs1=0 -> no stall.
//   6. Assert rst_n=0 mid-stall between edges -> out_valid=0 and in_ready recovers
//      immediately; busy[] cleared; r5 reads 0.

Source files
------------

// File: rtl/alu_issue.sv
// Operand-fetch / issue stage feeding the ALU: register file, busy
// scoreboard, hazard stall and a one-entry registered issue slot.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RIDX-1:0] in_rs1,
  input  logic [RIDX-1:0] in_rs2,
  input  logic [RIDX-1:0] in_rd,
  input  logic            in_wen,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_aluc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_aluc,
  output logic [RIDX-1:0] out_rd,
  output logic            out_wen,
  input  logic            wb_valid,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            hit1;
  logic            hit2;
  logic            hitd;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;

  assign hit1 = wb_valid && (wb_rd == in_rs1);
  assign hit2 = wb_valid && (wb_rd == in_rs2);
  assign hitd = wb_valid && (wb_rd == in_rd);

  // A writeback landing this cycle both forwards data and lifts the stall.
  assign rs1_val = (in_rs1 == '0) ? '0
                 : hit1 ? wb_data
                 : rf_q[in_rs1];
  assign rs2_val = (in_rs2 == '0) ? '0
                 : hit2 ? wb_data
                 : rf_q[in_rs2];

  assign a_d = rs1_val;
  assign b_d = in_use_imm ? in_imm : rs2_val;

  assign hazard = (busy_q[in_rs1] && !hit1)
               || (!in_use_imm && busy_q[in_rs2] && !hit2)
               || (in_wen && busy_q[in_rd] && !hitd);

  assign out_valid = (state_q == FULL);
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // Set after clear so a same-cycle set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && in_wen) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_valid && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      busy_q   <= '0;
      out_a    <= '0;
      out_b    <= '0;
      out_aluc <= '0;
      out_rd   <= '0;
      out_wen  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (out_ready && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        out_a    <= a_d;
        out_b    <= b_d;
        out_aluc <= in_aluc;
        out_rd   <= in_rd;
        out_wen  <= in_wen;
      end
    end
  end

endmodule
